control_unit: RTL
=================

// Module: control_unit
// PURPOSE
//  Microcode sequencer for the 8-bit bus machine. Steps each instruction through
//  fetch (T0-T1) and execute (T2-T4), driving one-hot control lines to PC, MAR,
//  RAM, IR, A, B, ALU and OUT. Keeps its own copy of the carry/zero flags for JC/JZ.
//  The ALU re-registers CF/ZF on every clock, so the flag copy is needed.
// PARAMETERS
//  none (opcode map and step table fixed below)
// PORTS
//  clk      in   1  system clock, all state on posedge
//  rst      in   1  synchronous, active-high reset
//  en       in   1  advance enable; 0 = pause (single-step / run control)
//  opcode   in   4  IR[7:4]; valid from T2 onward
//  cf, zf   in   1  registered ALU flags (CF, ZF)
//  pc_out, pc_inc, jump, mar_in, ram_out, ram_in, ir_in, ir_out  out 1 each
//  a_in, a_out, b_in, alu_out, sub, out_in, hlt                 out 1 each
//  step     out  3  current T-state 0..4
//  halted   out  1  sticky halt status
// BEHAVIOUR
//  Reset state: step=0, flag_c=0, flag_z=0, flag_pend=0, halted=0.
//  While rst=1, every control output is 0.
//  Control outputs are decoded combinationally from registered step/opcode/flags.
//  All control outputs except hlt are forced to 0 when en=0 or halted=1.
//  Step counter: advances on an en=1 edge. After the instruction's last step it
//  returns to 0. With en=0 it holds.
//  Fetch, all opcodes: T0 pc_out,mar_in | T1 ram_out,ir_in,pc_inc
//  Execute (last listed step ends the instruction; len = total cycles):
//   0000 NOP       T2 none                                   len 3
//   0001 LDA       T2 ir_out,mar_in  T3 ram_out,a_in         len 4
//   0010 ADD       T2 ir_out,mar_in  T3 ram_out,b_in  T4 alu_out,a_in   len 5
//   0011 SUB       as ADD, plus sub=1 in T4 only             len 5
//   0100 STA       T2 ir_out,mar_in  T3 a_out,ram_in         len 4
//   0101 LDI       T2 ir_out,a_in                            len 3
//   0110 JMP       T2 ir_out,jump                            len 3
//   0111 JC        T2 ir_out; jump only if flag_c=1          len 3
//   1000 JZ        T2 ir_out; jump only if flag_z=1          len 3
//   1110 OUT       T2 a_out,out_in                           len 3
//   1111 HLT       T2 hlt                                    see halt
//   other          treated as NOP                            len 3
//  Flag capture: an en=1 edge that ends T4 of ADD/SUB sets flag_pend. The next
//  posedge copies cf->flag_c and zf->flag_z and clears flag_pend. This happens
//  regardless of en, so a pause just after T4 cannot pick up stale ALU flags.
//  Other instructions leave flag_c/flag_z unchanged.
//  Halt: an en=1 edge in T2 of HLT sets halted=1. step then stays 2 and hlt=1
//  until rst. In T2 of HLT, hlt=1 even when en=0. pc_inc never asserts while halted.
//  Reset mid-instruction abandons the instruction and clears all state above.
//  The first cycle after rst falls is T0.
//  step encoding is 3 bits; values 5-7 are unreachable. If reached, treat as the
//  end of the instruction: controls 0, next step=0.
// TESTING
//  1 rst=1 for 2 clk -> all controls 0, step=0, halted=0; rst=0 -> pc_out=mar_in=1
//    (T0), next cycle ram_out=ir_in=pc_inc=1.
//  2 opcode=0001, en=1 -> T2 ir_out+mar_in, T3 ram_out+a_in, cycle 5 step=0 (len 4).
//  3 SUB, cf=1 zf=1 driven on the cycle after T4 -> sub=1 only in T4 with
//    alu_out+a_in. Following JZ: jump=1 in T2. Following JC with cf captured 0:
//    jump=0 in T2, len 3.
//  4 ADD, en=0 for 3 cycles at T3 -> all controls 0, step=3 held; en=1 -> b_in=1.
//    en=0 right after T4 with cf=1 -> flag_c=1 next edge anyway.
//  5 opcode=1111 -> hlt=1, halted=1, step=2 for 10+ cycles, no pc_inc;
//    rst pulse -> halted=0, T0.
//  6 opcode=1010 -> T2 all controls 0, step back to 0 after 3 cycles;
//    rst asserted at T3 of LDA -> a_in never asserted, step=0.

Source files
------------

// File: rtl/control_unit.sv
// Microcode sequencer for the 8-bit bus machine: fetch/execute T-state counter,
// one-hot control decode, private carry/zero flag copy for JC/JZ, and sticky halt.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] opcode,
  input  logic       cf,
  input  logic       zf,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       jump,
  output logic       mar_in,
  output logic       ram_out,
  output logic       ram_in,
  output logic       ir_in,
  output logic       ir_out,
  output logic       a_in,
  output logic       a_out,
  output logic       b_in,
  output logic       alu_out,
  output logic       sub,
  output logic       out_in,
  output logic       hlt,
  output logic [2:0] step,
  output logic       halted
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_t;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  tstate_t    state_reg;
  logic       flag_c_reg;
  logic       flag_z_reg;
  logic       flag_pend_reg;
  logic       halted_reg;
  logic [2:0] last_step;
  logic       is_last;
  logic       is_alu_op;
  logic       active;

  assign is_alu_op = (opcode == OP_ADD) || (opcode == OP_SUB);

  always_comb begin
    last_step = 3'd2;
    case (opcode)
      OP_LDA, OP_STA: last_step = 3'd3;
      OP_ADD, OP_SUB: last_step = 3'd4;
      default:        last_step = 3'd2;
    endcase
  end

  // ">=" also folds the unreachable encodings 5-7 into end-of-instruction.
  assign is_last = (state_reg >= last_step);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= T0;
      flag_c_reg    <= 1'b0;
      flag_z_reg    <= 1'b0;
      flag_pend_reg <= 1'b0;
      halted_reg    <= 1'b0;
    end else begin
      // ALU flags are valid one edge after T4 ends; capture even while paused.
      if (flag_pend_reg) begin
        flag_c_reg    <= cf;
        flag_z_reg    <= zf;
        flag_pend_reg <= 1'b0;
      end
      if (en && !halted_reg) begin
        if (state_reg == T2 && opcode == OP_HLT) begin
          halted_reg <= 1'b1;
        end else if (is_last) begin
          state_reg <= T0;
          if (state_reg == T4 && is_alu_op)
            flag_pend_reg <= 1'b1;
        end else begin
          state_reg <= tstate_t'(state_reg + 3'd1);
        end
      end
    end
  end

  assign active = en && !halted_reg && !rst;
  assign step   = state_reg;
  assign halted = halted_reg;
  assign hlt    = !rst && (halted_reg || (state_reg == T2 && opcode == OP_HLT));

  always_comb begin
    {pc_out, pc_inc, jump, mar_in, ram_out, ram_in, ir_in, ir_out} = '0;
    {a_in, a_out, b_in, alu_out, sub, out_in} = '0;
    if (active) begin
      case (state_reg)
        T0: {pc_out, mar_in} = 2'b11;
        T1: {ram_out, ir_in, pc_inc} = 3'b111;
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: {ir_out, mar_in} = 2'b11;
            OP_LDI: {ir_out, a_in} = 2'b11;
            OP_JMP: {ir_out, jump} = 2'b11;
            OP_JC: begin
              ir_out = 1'b1;
              jump   = flag_c_reg;
            end
            OP_JZ: begin
              ir_out = 1'b1;
              jump   = flag_z_reg;
            end
            OP_OUT: {a_out, out_in} = 2'b11;
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA:         {ram_out, a_in} = 2'b11;
            OP_ADD, OP_SUB: {ram_out, b_in} = 2'b11;
            OP_STA:         {a_out, ram_in} = 2'b11;
            default: ;
          endcase
        end
        T4: begin
          if (is_alu_op) begin
            {alu_out, a_in} = 2'b11;
            sub = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
